// File: rtl/cart_rom_arbiter.sv
// Cartridge ROM arbiter: shares one single-port, fixed-latency ROM store
// between the two Game Boy cart read paths and the ioctl download writer.
// Downloads always win arbitration; the two readers alternate round-robin
// when both are waiting. One access is in flight at a time.
module cart_rom_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_mode,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_ack,
  input  logic          rd0_req,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_ack,
  output logic [DW-1:0] rd0_data,
  input  logic          rd1_req,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_ack,
  output logic [DW-1:0] rd1_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_RD0, G_RD1, G_WR} gnt_t;

  // WAIT lasts MEM_LAT cycles; read data is valid in its last cycle.
  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t        state_q;
  gnt_t          gnt_q;
  logic [CW-1:0] cnt_q;
  logic          rr_q;
  logic          dl_ack_q;
  logic          rd0_ack_q;
  logic          rd1_ack_q;
  logic [DW-1:0] rd0_data_q;
  logic [DW-1:0] rd1_data_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          rd_pick_d;

  // Reader selection: round-robin pointer breaks ties, otherwise the lone requester.
  always_comb begin
    rd_pick_d = 1'b0;
    if (rd0_req && rd1_req) begin
      rd_pick_d = rr_q;
    end else if (rd1_req) begin
      rd_pick_d = 1'b1;
    end
  end

  // Arbitration FSM with registered memory strobes, acks and read data.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_RD0;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      dl_ack_q   <= 1'b0;
      rd0_ack_q  <= 1'b0;
      rd1_ack_q  <= 1'b0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      dl_ack_q  <= 1'b0;
      rd0_ack_q <= 1'b0;
      rd1_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dl_req) begin
            gnt_q      <= G_WR;
            mem_addr_q <= dl_addr;
            mem_din_q  <= dl_data;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end else if (!dl_mode && (rd0_req || rd1_req)) begin
            gnt_q      <= rd_pick_d ? G_RD1 : G_RD0;
            mem_addr_q <= rd_pick_d ? rd1_addr : rd0_addr;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          cnt_q     <= '0;
          if (gnt_q == G_WR) begin
            dl_ack_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            if (gnt_q == G_RD1) begin
              rd1_data_q <= mem_dout;
              rd1_ack_q  <= 1'b1;
            end else begin
              rd0_data_q <= mem_dout;
              rd0_ack_q  <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Next tie goes to the reader that was not just served.
          if (gnt_q != G_WR) begin
            rr_q <= (gnt_q == G_RD0);
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dl_ack   = dl_ack_q;
  assign rd0_ack  = rd0_ack_q;
  assign rd1_ack  = rd1_ack_q;
  assign rd0_data = rd0_data_q;
  assign rd1_data = rd1_data_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Bench for cart_rom_arbiter: directed scenarios followed by randomized
// requester traffic, checked every cycle against a transaction-level model.
module tb_cart_rom_arbiter;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dl_mode;
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_ack;
  logic          rd0_req;
  logic [AW-1:0] rd0_addr;
  logic          rd0_ack;
  logic [DW-1:0] rd0_data;
  logic          rd1_req;
  logic [AW-1:0] rd1_addr;
  logic          rd1_ack;
  logic [DW-1:0] rd1_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk_sys = ~clk_sys;

  cart_rom_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_mode(dl_mode),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack), .rd1_data(rd1_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Memory: 16 words indexed by addr[3:0], read data valid LAT cycles after mem_req.
  logic [DW-1:0] init_val [16];
  logic [DW-1:0] ram      [16];
  logic [DW-1:0] pipe     [LAT];

  always @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val[i];
    end else if (mem_req && mem_we) begin
      ram[mem_addr[3:0]] <= mem_din;
    end
    pipe[0] <= (mem_req && !mem_we) ? ram[mem_addr[3:0]] : DW'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, k);
    end
  endtask

  // Transaction-level reference: one access at a time, arbiter free again the
  // cycle after the ack; ties between readers go to the one not served last.
  int            free_at = 0;
  bit            have    = 0;
  int            t_issue, t_ack, t_id;
  bit            t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  bit            pref    = 0;
  logic [DW-1:0] gold [16];
  logic [DW-1:0] e_d0 = '0;
  logic [DW-1:0] e_d1 = '0;
  bit            rst_prev = 0;
  int            ack_now  = -1;

  task automatic model_eval();
    int id;
    if (reset) begin
      have = 0; pref = 0; e_d0 = '0; e_d1 = '0; free_at = k + 1; rst_prev = 1;
      for (int i = 0; i < 16; i++) gold[i] = init_val[i];
    end else begin
      rst_prev = 0;
      if (k >= free_at) begin
        id = -1;
        if (dl_req) id = 2;
        else if (!dl_mode) begin
          if (rd0_req && rd1_req) id = int'(pref);
          else if (rd0_req)       id = 0;
          else if (rd1_req)       id = 1;
        end
        if (id >= 0) begin
          have    = 1;
          t_id    = id;
          t_we    = (id == 2);
          t_issue = k + 1;
          t_ack   = t_we ? k + 2 : k + LAT + 2;
          free_at = t_ack + 1;
          t_addr  = (id == 2) ? dl_addr : (id == 0) ? rd0_addr : rd1_addr;
          if (t_we) begin
            t_data = dl_data;
            gold[t_addr[3:0]] = dl_data;
          end else begin
            t_data = gold[t_addr[3:0]];
            pref   = (id == 0);
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_mr;
    ack_now = -1;
    exp_mr  = have && (k == t_issue);
    chk("mem_req", 32'(mem_req), 32'(exp_mr));
    chk("mem_we", 32'(mem_we), 32'(exp_mr && t_we));
    if (exp_mr) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      if (t_we) chk("mem_din", 32'(mem_din), 32'(t_data));
    end
    if (have && (k == t_ack)) begin
      ack_now = t_id;
      if (t_id == 0) e_d0 = t_data;
      if (t_id == 1) e_d1 = t_data;
    end
    chk("dl_ack", 32'(dl_ack), 32'(ack_now == 2));
    chk("rd0_ack", 32'(rd0_ack), 32'(ack_now == 0));
    chk("rd1_ack", 32'(rd1_ack), 32'(ack_now == 1));
    chk("rd0_data", 32'(rd0_data), 32'(e_d0));
    chk("rd1_data", 32'(rd1_data), 32'(e_d1));
    if (rst_prev) begin
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_din", 32'(mem_din), 32'h0);
    end
  endtask

  // Inputs for cycle k are already driven; let the edge happen and check.
  task automatic step();
    model_eval();
    @(posedge clk_sys);
    k++;
    @(negedge clk_sys);
    check_outputs();
  endtask

  task automatic idle(input int n);
    dl_req = 0; rd0_req = 0; rd1_req = 0; dl_mode = 0;
    repeat (n) step();
  endtask

  function automatic bit next_want(bit cur, bit acked, bit granted);
    if (acked)          return ($urandom_range(1, 0) == 1);
    if (cur && granted) return ($urandom_range(7, 0) != 0);
    if (!cur)           return ($urandom_range(5, 0) == 0);
    return cur;
  endfunction

  task automatic rand_drive();
    bit g0, g1, g2;
    g0 = have && t_id == 0 && k < t_ack;
    g1 = have && t_id == 1 && k < t_ack;
    g2 = have && t_id == 2 && k < t_ack;
    if (ack_now == 0 || g0 || !rd0_req) rd0_addr = AW'($urandom);
    if (ack_now == 1 || g1 || !rd1_req) rd1_addr = AW'($urandom);
    if (ack_now == 2 || g2 || !dl_req) begin
      dl_addr = AW'($urandom);
      dl_data = DW'($urandom);
    end
    rd0_req = next_want(rd0_req, ack_now == 0, g0);
    rd1_req = next_want(rd1_req, ack_now == 1, g1);
    dl_req  = next_want(dl_req, ack_now == 2, g2) && ($urandom_range(2, 0) == 0 || dl_req);
    if ($urandom_range(39, 0) == 0) dl_mode = ~dl_mode;
    reset = ($urandom_range(399, 0) == 0);
  endtask

  int ids[$];
  int cyc[$];
  int n;
  logic [DW-1:0] got_d;

  initial begin
    for (int i = 0; i < 16; i++) init_val[i] = DW'(16'h1000 + i * 16'h0311);
    init_val[3] = 16'hBEEF;
    reset = 1; dl_mode = 0; dl_req = 0; rd0_req = 0; rd1_req = 0;
    dl_addr = '0; dl_data = '0; rd0_addr = '0; rd1_addr = '0;
    @(negedge clk_sys);
    repeat (3) step();
    reset = 0;
    idle(2);

    // Single read with fixed latency.
    rd0_req = 1; rd0_addr = 24'h000123;
    step();
    chk("single_mreq", 32'(mem_req), 32'h1);
    chk("single_maddr", 32'(mem_addr), 32'h000123);
    rd0_addr = 24'h0ABCDE;
    n = 0;
    while (rd0_ack !== 1'b1 && n < 20) begin step(); n++; end
    rd0_req = 0;
    chk("single_lat", 32'(n + 1), 32'(LAT + 2));
    chk("single_data", 32'(rd0_data), 32'hBEEF);
    idle(3);

    // Contention from reset: strict alternation, fixed spacing.
    reset = 1; rd0_req = 1; rd1_req = 1;
    rd0_addr = AW'($urandom); rd1_addr = AW'($urandom);
    step();
    reset = 0;
    for (int c = 0; c < 40 && ids.size() < 4; c++) begin
      step();
      if (rd0_ack) begin ids.push_back(0); cyc.push_back(k); rd0_addr = AW'($urandom); end
      if (rd1_ack) begin ids.push_back(1); cyc.push_back(k); rd1_addr = AW'($urandom); end
    end
    chk("cont_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < ids.size(); i++) begin
      chk("cont_order", 32'(ids[i]), 32'(i % 2));
      if (i > 0) chk("cont_spacing", 32'(cyc[i] - cyc[i-1]), 32'(LAT + 3));
    end
    idle(LAT + 4);

    // Download priority and dl_mode read stall.
    reset = 1; step(); reset = 0;
    dl_mode = 1; dl_req = 1; dl_addr = 24'h000010; dl_data = 16'h1234;
    rd0_req = 1; rd0_addr = 24'h000010; rd1_req = 1; rd1_addr = 24'h000025;
    step();
    chk("dl_we", 32'(mem_we), 32'h1);
    chk("dl_maddr", 32'(mem_addr), 32'h000010);
    chk("dl_mdin", 32'(mem_din), 32'h1234);
    step();
    chk("dl_ack_lat", 32'(dl_ack), 32'h1);
    dl_req = 0;
    n = 0;
    repeat (10) begin step(); if (rd0_ack || rd1_ack) n++; end
    chk("dl_stall", 32'(n), 32'h0);
    dl_mode = 0;
    n = 0;
    while (!(rd0_ack || rd1_ack) && n < 20) begin step(); n++; end
    chk("dl_first_rd0", 32'(rd0_ack), 32'h1);
    chk("dl_rdata", 32'(rd0_data), 32'h1234);
    rd0_req = 0;
    n = 0;
    while (rd1_ack !== 1'b1 && n < 20) begin step(); n++; end
    rd1_req = 0;
    chk("dl_rd1_ack", 32'(rd1_ack), 32'h1);
    idle(3);

    // Reset while the read waits on memory.
    rd0_req = 1; rd0_addr = 24'h000457;
    step(); step(); step();
    reset = 1; rd0_req = 0;
    step();
    chk("rst_mid_ack", 32'(rd0_ack), 32'h0);
    chk("rst_mid_mreq", 32'(mem_req), 32'h0);
    chk("rst_mid_data", 32'(rd0_data), 32'h0);
    chk("rst_mid_addr", 32'(mem_addr), 32'h0);
    reset = 0;
    n = 0;
    repeat (8) begin step(); if (rd0_ack) n++; end
    chk("rst_no_ack", 32'(n), 32'h0);
    rd1_req = 1; rd1_addr = 24'h000A05;
    n = 0;
    step();
    while (rd1_ack !== 1'b1 && n < 20) begin step(); n++; end
    rd1_req = 0;
    chk("rst_rd1_ack", 32'(rd1_ack), 32'h1);
    chk("rst_rd1_data", 32'(rd1_data), 32'(init_val[5]));
    idle(3);

    // Request pulsed for a single idle cycle.
    rd1_req = 1; rd1_addr = 24'h123458;
    step();
    rd1_req = 0;
    n = 0; got_d = '0;
    repeat (12) begin
      step();
      if (rd1_ack) begin n++; got_d = rd1_data; end
    end
    chk("drop_acks", 32'(n), 32'h1);
    chk("drop_data", 32'(got_d), 32'(init_val[8]));
    chk("drop_rd0_kept", 32'(rd0_data), 32'h0);

    // Randomized traffic.
    repeat (1500) begin
      rand_drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
